// File: rtl/vga_fb_prefetcher.sv
// Frame-buffer prefetcher: burst-reads one frame from SDRAM into a
// local FIFO and streams it out as a single Avalon-ST packet.
module vga_fb_prefetcher #(
    parameter int PIXEL_WIDTH       = 16,
    parameter int ADDR_WIDTH        = 24,
    parameter int CSR_DATA_WIDTH    = 32,
    parameter int CSR_START_ADDRESS = 0,
    parameter int FB_BASE_ADDR      = 0,
    parameter int FRAME_PIXELS      = 307200,
    parameter int BURST_LEN         = 8,
    parameter int FIFO_DEPTH        = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        csr_write,
    input  logic [ADDR_WIDTH-1:0]       csr_address,
    input  logic [CSR_DATA_WIDTH-1:0]   csr_writedata,
    output logic                        csr_waitrequest,
    output logic                        mm_read,
    output logic [ADDR_WIDTH-1:0]       mm_address,
    output logic [$clog2(BURST_LEN):0]  mm_burstcount,
    input  logic                        mm_waitrequest,
    input  logic [PIXEL_WIDTH-1:0]      mm_readdata,
    input  logic                        mm_readdatavalid,
    input  logic                        st_ready,
    output logic [PIXEL_WIDTH-1:0]      st_data,
    output logic                        st_startofpacket,
    output logic                        st_endofpacket,
    output logic                        st_valid
);

    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int RW = $clog2(FRAME_PIXELS + 1);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = OW + 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [RW-1:0]          req_left;
    logic [RW-1:0]          out_cnt;
    logic [OW-1:0]          outstanding;
    logic [OW-1:0]          fifo_count;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PIXEL_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic          start_hit;
    logic          start_acc;
    logic          fetching;
    logic          last_pix;
    logic          push;
    logic          pop;
    logic          cmd_acc;
    logic          can_issue;
    logic [BW-1:0] blen;
    logic [SW-1:0] occ;
    logic          csr_unused;

    assign csr_unused = ^csr_writedata;

    assign start_hit = csr_write
                    && csr_address == ADDR_WIDTH'(CSR_START_ADDRESS)
                    && csr_writedata[0];

    assign csr_waitrequest = start_hit && (outstanding != '0 || mm_read);
    assign start_acc = start_hit && !csr_waitrequest;

    assign fetching = state_q == FETCH;
    assign last_pix = out_cnt == RW'(FRAME_PIXELS - 1);

    assign st_valid         = fetching && fifo_count != '0;
    assign st_data          = st_valid ? fifo_mem[rd_ptr] : '0;
    assign st_startofpacket = st_valid && out_cnt == '0;
    assign st_endofpacket   = st_valid && last_pix;

    assign pop     = st_valid && st_ready;
    assign push    = fetching && mm_readdatavalid;
    assign cmd_acc = mm_read && !mm_waitrequest;

    // Reserve room for every word already requested so the FIFO
    // cannot overflow regardless of how fast data returns.
    always_comb begin
        blen = BW'(BURST_LEN);
        if (32'(req_left) < BURST_LEN)
            blen = BW'(req_left);
        occ = SW'(fifo_count) + SW'(outstanding) + SW'(blen);
        can_issue = fetching
                 && req_left != '0
                 && !start_hit
                 && !mm_read
                 && occ <= SW'(FIFO_DEPTH);
    end

    always_comb begin
        state_d = state_q;
        if (start_acc)
            state_d = FETCH;
        else if (fetching && pop && last_pix)
            state_d = DONE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mm_read       <= 1'b0;
            mm_address    <= '0;
            mm_burstcount <= '0;
            req_addr      <= '0;
            req_left      <= '0;
            out_cnt       <= '0;
            outstanding   <= '0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else if (start_acc) begin
            mm_read     <= 1'b0;
            req_addr    <= ADDR_WIDTH'(FB_BASE_ADDR);
            req_left    <= RW'(FRAME_PIXELS);
            out_cnt     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (cmd_acc) begin
                mm_read  <= 1'b0;
                req_addr <= req_addr + ADDR_WIDTH'(mm_burstcount);
                req_left <= req_left - RW'(mm_burstcount);
            end else if (can_issue) begin
                mm_read       <= 1'b1;
                mm_address    <= req_addr;
                mm_burstcount <= blen;
            end
            outstanding <= outstanding
                         + (cmd_acc ? OW'(mm_burstcount) : OW'(0))
                         - OW'(push);
            fifo_count  <= fifo_count + OW'(push) - OW'(pop);
            wr_ptr      <= wr_ptr + PW'(push);
            rd_ptr      <= rd_ptr + PW'(pop);
            out_cnt     <= out_cnt + RW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mm_readdata;
    end

    rdv_only_in_fetch: assert property (
        @(posedge clk) disable iff (reset)
        mm_readdatavalid |-> state_q == FETCH
    );

endmodule

// File: tb/tb_vga_fb_prefetcher.sv
// Scoreboard bench for vga_fb_prefetcher with a small SDRAM model
// returning {frame tag, address[11:0]} as pixel data.
module tb_vga_fb_prefetcher;

    localparam int          NPIX  = 20;
    localparam int          BL    = 8;
    localparam int          FD    = 16;
    localparam logic [15:0] FB    = 16'h0100;
    localparam logic [15:0] START = 16'd2;

    logic        clk;
    logic        reset;
    logic        csr_write;
    logic [15:0] csr_address;
    logic [31:0] csr_writedata;
    logic        csr_waitrequest;
    logic        mm_read;
    logic [15:0] mm_address;
    logic [3:0]  mm_burstcount;
    logic        mm_waitrequest;
    logic [15:0] mm_readdata;
    logic        mm_readdatavalid;
    logic        st_ready;
    logic [15:0] st_data;
    logic        st_startofpacket;
    logic        st_endofpacket;
    logic        st_valid;

    vga_fb_prefetcher #(
        .PIXEL_WIDTH      (16),
        .ADDR_WIDTH       (16),
        .CSR_DATA_WIDTH   (32),
        .CSR_START_ADDRESS(2),
        .FB_BASE_ADDR     (int'(FB)),
        .FRAME_PIXELS     (NPIX),
        .BURST_LEN        (BL),
        .FIFO_DEPTH       (FD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .csr_write       (csr_write),
        .csr_address     (csr_address),
        .csr_writedata   (csr_writedata),
        .csr_waitrequest (csr_waitrequest),
        .mm_read         (mm_read),
        .mm_address      (mm_address),
        .mm_burstcount   (mm_burstcount),
        .mm_waitrequest  (mm_waitrequest),
        .mm_readdata     (mm_readdata),
        .mm_readdatavalid(mm_readdatavalid),
        .st_ready        (st_ready),
        .st_data         (st_data),
        .st_startofpacket(st_startofpacket),
        .st_endofpacket  (st_endofpacket),
        .st_valid        (st_valid)
    );

    int checks = 0;
    int fails  = 0;

    logic [17:0] sb[$];
    logic [19:0] exp_cmd[$];
    logic [15:0] pend[$];

    logic [3:0]  tag = 0;
    logic [1:0]  ready_mode = 0;
    int          mem_allow = 1000000;
    int          mem_wait = 0;
    int unsigned rdv_pct = 100;
    int unsigned wr_pct = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic accept_cmd();
        logic [15:0] a;
        if (exp_cmd.size() == 0)
            chk("burst_unexpected", 32'(mm_address), 32'hffff_ffff);
        else
            chk("burst", 32'({mm_address, mm_burstcount}),
                32'(exp_cmd.pop_front()));
        for (int i = 0; i < int'(mm_burstcount); i++) begin
            a = mm_address + 16'(i);
            pend.push_back({tag, a[11:0]});
        end
    endtask

    // SDRAM model: drives at negedge for the next posedge
    initial begin
        int hold;
        hold = 0;
        mm_waitrequest   = 0;
        mm_readdatavalid = 0;
        mm_readdata      = '0;
        forever begin
            @(negedge clk);
            if (pend.size() > 0 && mem_allow > 0
                && $urandom_range(99) < rdv_pct) begin
                mm_readdatavalid = 1;
                mm_readdata      = pend.pop_front();
                mem_allow--;
            end else begin
                mm_readdatavalid = 0;
            end
            if (mm_read && !reset) begin
                if (hold < mem_wait || $urandom_range(99) < wr_pct) begin
                    mm_waitrequest = 1;
                    hold++;
                end else begin
                    mm_waitrequest = 0;
                    hold = 0;
                    accept_cmd();
                end
            end else begin
                mm_waitrequest = 0;
                hold = 0;
            end
        end
    end

    initial begin
        st_ready = 0;
        forever begin
            @(negedge clk);
            if (ready_mode == 2)
                st_ready = 1'($urandom_range(1));
            else
                st_ready = ready_mode[0];
        end
    end

    // Monitor: pops the scoreboard on every accepted beat
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && st_valid && st_ready) begin
                if (sb.size() == 0) begin
                    chk("beat_unexpected", 32'(st_data), 32'hffff_ffff);
                end else begin
                    e = sb.pop_front();
                    chk("beat", 32'({st_data, st_startofpacket,
                                     st_endofpacket}), 32'(e));
                end
            end
        end
    end

    // A stalled command must hold until accepted
    initial begin
        logic        stall;
        logic [19:0] cmd;
        stall = 0;
        cmd   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (stall)
                chk("cmd_stable",
                    32'({mm_read, mm_address, mm_burstcount}),
                    32'({1'b1, cmd}));
            stall = mm_read && mm_waitrequest && !reset;
            cmd   = {mm_address, mm_burstcount};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic csr_wr(input logic [15:0] a, input logic [31:0] d,
                          input int allow_after, output logic first_wr);
        int n;
        @(negedge clk);
        csr_write     = 1;
        csr_address   = a;
        csr_writedata = d;
        #2;
        first_wr = csr_waitrequest;
        if (allow_after >= 0)
            mem_allow = allow_after;
        n = 0;
        while (csr_waitrequest && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("csr_wr_done", 32'(csr_waitrequest), 0);
        @(negedge clk);
        csr_write     = 0;
        csr_writedata = '0;
    endtask

    task automatic start_frame(input int allow_after, output logic w);
        logic [15:0] a;
        csr_wr(START, 32'd1, allow_after, w);
        tag++;
        sb.delete();
        exp_cmd.delete();
        for (int i = 0; i < NPIX; i++) begin
            a = FB + 16'(i);
            sb.push_back({tag, a[11:0], i == 0, i == NPIX - 1});
        end
        exp_cmd.push_back({FB, 4'd8});
        exp_cmd.push_back({FB + 16'd8, 4'd8});
        exp_cmd.push_back({FB + 16'd16, 4'd4});
    endtask

    task automatic wait_frame_done(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("frame_complete", 32'(sb.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cmds_left(input int left, input int bound);
        int n;
        n = 0;
        while (exp_cmd.size() != left && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("cmds_left", 32'(exp_cmd.size()), 32'(left));
    endtask

    initial begin
        logic w;
        int   n;
        reset         = 1;
        csr_write     = 0;
        csr_address   = '0;
        csr_writedata = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_mm_read", 32'(mm_read), 0);
        chk("rst_mm_address", 32'(mm_address), 0);
        chk("rst_burstcount", 32'(mm_burstcount), 0);
        chk("rst_st_valid", 32'(st_valid), 0);
        chk("rst_sop", 32'(st_startofpacket), 0);
        chk("rst_eop", 32'(st_endofpacket), 0);
        chk("rst_st_data", 32'(st_data), 0);
        chk("rst_csr_wait", 32'(csr_waitrequest), 0);
        @(negedge clk);
        reset = 0;
        repeat (5) @(negedge clk);
        chk("idle_no_read", 32'(mm_read), 0);

        // Full frame, free-running sink and SDRAM
        ready_mode = 1;
        start_frame(-1, w);
        chk("start_no_wait", 32'(w), 0);
        wait_frame_done(200);
        repeat (20) @(negedge clk);
        #2;
        chk("done_no_read", 32'(mm_read), 0);
        chk("done_no_valid", 32'(st_valid), 0);
        chk("done_cmds", 32'(exp_cmd.size()), 0);

        // Writes that must not start a frame
        csr_wr(START, 32'd2, -1, w);
        chk("bit0_clear_wait", 32'(w), 0);
        csr_wr(START + 16'd1, 32'd1, -1, w);
        chk("wrong_addr_wait", 32'(w), 0);
        repeat (10) @(negedge clk);
        #2;
        chk("ignored_no_read", 32'(mm_read), 0);
        chk("ignored_no_valid", 32'(st_valid), 0);

        // Reset in the middle of a frame
        ready_mode = 0;
        mem_allow  = 3;
        start_frame(-1, w);
        wait_cmds_left(1, 100);
        repeat (10) @(negedge clk);
        #2;
        chk("pre_rst_valid", 32'(st_valid), 1);
        chk("pre_rst_sop", 32'(st_startofpacket), 1);
        chk("pre_rst_data", 32'(st_data), 32'({tag, FB[11:0]}));
        @(negedge clk);
        reset = 1;
        pend.delete();
        @(negedge clk);
        #2;
        chk("mid_rst_mm_read", 32'(mm_read), 0);
        chk("mid_rst_address", 32'(mm_address), 0);
        chk("mid_rst_burstcount", 32'(mm_burstcount), 0);
        chk("mid_rst_valid", 32'(st_valid), 0);
        chk("mid_rst_sop", 32'(st_startofpacket), 0);
        chk("mid_rst_data", 32'(st_data), 0);
        @(negedge clk);
        reset = 0;
        sb.delete();
        exp_cmd.delete();
        mem_allow = 1000000;
        repeat (3) @(negedge clk);

        // Stalled sink fills the FIFO exactly
        ready_mode = 0;
        start_frame(-1, w);
        repeat (60) @(negedge clk);
        #2;
        chk("third_burst_held", 32'(exp_cmd.size()), 1);
        chk("all_data_in_fifo", 32'(pend.size()), 0);
        chk("stall_valid", 32'(st_valid), 1);
        chk("stall_no_read", 32'(mm_read), 0);
        ready_mode = 1;
        wait_frame_done(200);

        // Restart with reads outstanding
        ready_mode = 0;
        mem_allow  = 0;
        start_frame(-1, w);
        wait_cmds_left(1, 100);
        mem_allow = 11;
        n = 0;
        while (mem_allow != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("pend_before_abort", 32'(pend.size()), 5);
        start_frame(5, w);
        chk("abort_waitrequest", 32'(w), 1);
        chk("abort_pend_drained", 32'(pend.size()), 0);
        #2;
        chk("abort_fifo_flushed", 32'(st_valid), 0);
        mem_allow  = 1000000;
        ready_mode = 1;
        wait_frame_done(200);

        // Command held by waitrequest for 3 cycles
        mem_wait = 3;
        start_frame(-1, w);
        wait_frame_done(300);
        chk("wait_cmds", 32'(exp_cmd.size()), 0);
        mem_wait = 0;

        // Random back-pressure, three back-to-back frames
        ready_mode = 2;
        wr_pct     = 30;
        rdv_pct    = 60;
        for (int f = 0; f < 3; f++) begin
            start_frame(-1, w);
            wait_frame_done(600);
            chk("rand_cmds", 32'(exp_cmd.size()), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
